mctrl_exc: RTL and testbench

- Next-generation multi-cycle MIPS control FSM for the single-bus CPU datapath. Replaces the fixed-latency controller.
- Adds:
  - wait-state stretching on MIO_ready, with a parametrised bus timeout counter;
  - precise exceptions: overflow, illegal opcode and bus timeout;
  - an external interrupt, taken only at instruction boundaries;
  - JAL, JR, LUI and the immediate ALU ops.
- Drives every datapath mux and enable each cycle, plus EPC/Cause write strobes.

---
 rtl/mctrl_pkg.sv | 79 +++++++
 rtl/mctrl_wait_timer.sv | 27 ++
 rtl/mctrl_exc.sv | 212 +++++++++++++++++++++
 tb/tb_mctrl_exc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes, ALU ops,
// exception causes and datapath mux selects.
package mctrl_pkg;

  typedef enum logic [4:0] {
    StIf      = 5'd0,
    StId      = 5'd1,
    StExR     = 5'd2,
    StExI     = 5'd3,
    StMemAddr = 5'd4,
    StMemRd   = 5'd5,
    StMemWr   = 5'd6,
    StWbLw    = 5'd7,
    StWbR     = 5'd8,
    StWbI     = 5'd9,
    StBeq     = 5'd10,
    StBne     = 5'd11,
    StJ       = 5'd12,
    StJal     = 5'd13,
    StJr      = 5'd14,
    StLui     = 5'd15,
    StExc     = 5'd16
  } state_e;

  typedef enum logic [1:0] {CauseInt, CauseOvf, CauseIll, CauseBus} cause_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpJal  = 6'b000011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLui  = 6'b001111;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] RegDstRt = 2'b00, RegDstRd  = 2'b01, RegDstRa  = 2'b10;
  localparam logic [1:0] MtrMdr   = 2'b00, MtrAlu    = 2'b01, MtrLui    = 2'b10, MtrPc  = 2'b11;
  localparam logic [1:0] SrcbB    = 2'b00, Srcb4     = 2'b01, SrcbImm   = 2'b10, SrcbSh = 2'b11;
  localparam logic [1:0] PcsAlu   = 2'b00, PcsAluOut = 2'b01, PcsJump   = 2'b10, PcsExc = 2'b11;

  // Returns {legal, alu_op} for an R-type funct field (JR is dispatched separately).
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    case (funct)
      FnAdd:   return {1'b1, AluAdd};
      FnSub:   return {1'b1, AluSub};
      FnAnd:   return {1'b1, AluAnd};
      FnOr:    return {1'b1, AluOr};
      FnXor:   return {1'b1, AluXor};
      FnNor:   return {1'b1, AluNor};
      FnSlt:   return {1'b1, AluSlt};
      FnSrl:   return {1'b1, AluSrl};
      default: return {1'b0, AluAnd};
    endcase
  endfunction

endpackage

// File: rtl/mctrl_wait_timer.sv
// Bus wait-state counter: counts stalled cycles and flags the last one allowed before timeout.
module mctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // High during the TIMEOUT-th waiting cycle; ready in that same cycle still wins.
  assign expire = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mctrl_exc.sv
// Multi-cycle MIPS control FSM with wait states, bus timeout, precise exceptions and
// interrupts taken only at instruction boundaries.
module mctrl_exc
  import mctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned STATE_W  = 5,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned INT_EN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Inst_in,
  input  logic                zero,
  input  logic                overflow,
  input  logic                MIO_ready,
  input  logic                int_req,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ALU_OP_W-1:0] ALU_operation,
  output logic [STATE_W-1:0]  state_out,
  output logic                CPU_MIO,
  output logic                IorD,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                Branch,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                EPCWrite,
  output logic                CauseWrite,
  output logic [1:0]          Cause,
  output logic                int_ack
);

  state_e     state_q, state_d, bnd_state;
  cause_e     cause_q, cause_d, bnd_cause;
  logic [5:0] opcode, funct;
  logic       r_legal, timer_expire, timer_en, timer_clr;
  logic [2:0] r_op, i_op, alu_op;
  logic       unused_in;

  assign opcode            = Inst_in[31:26];
  assign funct             = Inst_in[5:0];
  assign {r_legal, r_op}   = funct_decode(funct);
  // zero is consumed by the datapath's PCWriteCond gating, not by the controller.
  assign unused_in         = ^{Inst_in[25:6], zero};

  always_comb begin
    case (opcode)
      OpAndi:  i_op = AluAnd;
      OpOri:   i_op = AluOr;
      OpSlti:  i_op = AluSlt;
      default: i_op = AluAdd;
    endcase
  end

  assign timer_en  = (state_q inside {StIf, StMemRd, StMemWr}) && !MIO_ready;
  assign timer_clr = (state_d != state_q);

  mctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    bnd_state = StIf;
    bnd_cause = cause_q;
    if (int_req && (INT_EN != 0)) begin
      bnd_state = StExc;
      bnd_cause = CauseInt;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StIf: begin
        if (MIO_ready) begin
          state_d = StId;
        end else if (timer_expire) begin
          state_d = StExc;
          cause_d = CauseBus;
        end
      end
      StId: begin
        case (opcode)
          OpR: begin
            if (funct == FnJr) begin
              state_d = StJr;
            end else if (r_legal) begin
              state_d = StExR;
            end else begin
              state_d = StExc;
              cause_d = CauseIll;
            end
          end
          OpLw, OpSw:                     state_d = StMemAddr;
          OpBeq:                          state_d = StBeq;
          OpBne:                          state_d = StBne;
          OpJ:                            state_d = StJ;
          OpJal:                          state_d = StJal;
          OpAddi, OpAndi, OpOri, OpSlti:  state_d = StExI;
          OpLui:                          state_d = StLui;
          default: begin
            state_d = StExc;
            cause_d = CauseIll;
          end
        endcase
      end
      StExR: begin
        if (overflow && (funct == FnAdd || funct == FnSub)) begin
          state_d = StExc;
          cause_d = CauseOvf;
        end else begin
          state_d = StWbR;
        end
      end
      StExI: begin
        if (overflow && opcode == OpAddi) begin
          state_d = StExc;
          cause_d = CauseOvf;
        end else begin
          state_d = StWbI;
        end
      end
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd, StMemWr: begin
        if (MIO_ready) begin
          state_d = (state_q == StMemRd) ? StWbLw : bnd_state;
          cause_d = (state_q == StMemRd) ? cause_q : bnd_cause;
        end else if (timer_expire) begin
          state_d = StExc;
          cause_d = CauseBus;
        end
      end
      StWbLw, StWbR, StWbI, StBeq, StBne, StJ, StJal, StJr, StLui: begin
        state_d = bnd_state;
        cause_d = bnd_cause;
      end
      StExc:   state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIf;
      cause_q <= CauseInt;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    MemRead = 1'b0;  MemWrite = 1'b0;    CPU_MIO = 1'b0;  IorD = 1'b0;
    IRWrite = 1'b0;  RegWrite = 1'b0;    ALUSrcA = 1'b0;  PCWrite = 1'b0;
    PCWriteCond = 1'b0;  Branch = 1'b0;  EPCWrite = 1'b0; CauseWrite = 1'b0;
    int_ack = 1'b0;  RegDst = RegDstRt;  MemtoReg = MtrMdr;
    ALUSrcB = SrcbB; PCSource = PcsAlu;  alu_op = AluAnd;
    // Everything is forced inactive while reset is held, including the IF fetch strobe.
    if (reset) begin
      unique case (state_q)
        StIf: begin
          MemRead = 1'b1;  CPU_MIO = 1'b1;  ALUSrcB = Srcb4;  alu_op = AluAdd;
          IRWrite = MIO_ready;  PCWrite = MIO_ready;
        end
        StId:      begin ALUSrcB = SrcbSh;  alu_op = AluAdd; end
        StExR:     begin ALUSrcA = 1'b1;    alu_op = r_op; end
        StExI:     begin ALUSrcA = 1'b1;    ALUSrcB = SrcbImm;  alu_op = i_op; end
        StMemAddr: begin ALUSrcA = 1'b1;    ALUSrcB = SrcbImm;  alu_op = AluAdd; end
        StMemRd:   begin IorD = 1'b1;       MemRead = 1'b1; end
        StMemWr:   begin IorD = 1'b1;       MemWrite = 1'b1; end
        StWbLw:    RegWrite = 1'b1;
        StWbR:     begin RegWrite = 1'b1;   RegDst = RegDstRd;  MemtoReg = MtrAlu; end
        StWbI:     begin RegWrite = 1'b1;   MemtoReg = MtrAlu; end
        StBeq, StBne: begin
          ALUSrcA = 1'b1;  alu_op = AluSub;  PCWriteCond = 1'b1;  PCSource = PcsAluOut;
          Branch = (state_q == StBeq);
        end
        StJ:       begin PCWrite = 1'b1;    PCSource = PcsJump; end
        StJal: begin
          PCWrite = 1'b1;  PCSource = PcsJump;  RegWrite = 1'b1;
          RegDst = RegDstRa;  MemtoReg = MtrPc;
        end
        StJr:      begin ALUSrcA = 1'b1;    alu_op = AluOr;  PCWrite = 1'b1; end
        StLui:     begin RegWrite = 1'b1;   MemtoReg = MtrLui; end
        StExc: begin
          EPCWrite = 1'b1;  CauseWrite = 1'b1;  PCWrite = 1'b1;  PCSource = PcsExc;
          int_ack = (cause_q == CauseInt);
        end
        default: ;
      endcase
    end
  end

  assign ALU_operation = ALU_OP_W'(alu_op);
  assign state_out     = STATE_W'(state_q);
  assign Cause         = cause_q;

endmodule

// File: tb/tb_mctrl_exc.sv
// Directed vector bench for mctrl_exc: per-cycle table of inputs and expected controls,
// plus a hand-written mid-access reset sequence.
module tb_mctrl_exc;

  localparam logic [4:0] StIf = 5'd0, StId = 5'd1, StExR = 5'd2, StExI = 5'd3, StMa = 5'd4;
  localparam logic [4:0] StMrd = 5'd5, StMwr = 5'd6, StWbLw = 5'd7, StWbR = 5'd8, StWbI = 5'd9;
  localparam logic [4:0] StBeq = 5'd10, StJal = 5'd13, StJr = 5'd14, StLui = 5'd15;
  localparam logic [4:0] StExc = 5'd16;

  // {MemRead,MemWrite,IorD,IRWrite,RegWrite,ALUSrcA,PCWrite,PCWriteCond,Branch,
  //  EPCWrite,CauseWrite,int_ack,CPU_MIO}
  localparam logic [12:0] CIfRdy  = 13'b1_0_0_1_0_0_1_0_0_0_0_0_1;
  localparam logic [12:0] CIfWait = 13'b1_0_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] CNone   = 13'b0;
  localparam logic [12:0] CSrcA   = 13'b0_0_0_0_0_1_0_0_0_0_0_0_0;
  localparam logic [12:0] CMemRd  = 13'b1_0_1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] CMemWr  = 13'b0_1_1_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] CRegW   = 13'b0_0_0_0_1_0_0_0_0_0_0_0_0;
  localparam logic [12:0] CBeq    = 13'b0_0_0_0_0_1_0_1_1_0_0_0_0;
  localparam logic [12:0] CJal    = 13'b0_0_0_0_1_0_1_0_0_0_0_0_0;
  localparam logic [12:0] CJr     = 13'b0_0_0_0_0_1_1_0_0_0_0_0_0;
  localparam logic [12:0] CExc    = 13'b0_0_0_0_0_0_1_0_0_1_1_0_0;
  localparam logic [12:0] CExcInt = 13'b0_0_0_0_0_0_1_0_0_1_1_1_0;

  // {RegDst,MemtoReg,ALUSrcB,PCSource}
  localparam logic [7:0] MIf = 8'b00_00_01_00, MId = 8'b00_00_11_00, MImm = 8'b00_00_10_00;
  localparam logic [7:0] M0 = 8'b0, MWbR = 8'b01_01_00_00, MWbI = 8'b00_01_00_00;
  localparam logic [7:0] MBeq = 8'b00_00_00_01, MJal = 8'b10_11_00_10;
  localparam logic [7:0] MLui = 8'b00_10_00_00, MExc = 8'b00_00_00_11;

  localparam logic [2:0] AAnd = 3'b000, AOr = 3'b001, AAdd = 3'b010, ASub = 3'b110;

  localparam logic [31:0] IAdd = 32'h0022_1820, ILw = 32'h8C22_0004, IOri = 32'h3422_0005;
  localparam logic [31:0] IBeq = 32'h1022_0003, IJal = 32'h0C00_0010, IJr = 32'h0020_0008;
  localparam logic [31:0] ILui = 32'h3C02_1234, IIll = 32'hFC00_0000, ISw = 32'hAC22_0008;

  typedef struct {
    logic [31:0] inst;
    logic        rdy, ovf, irq;
    logic [4:0]  st;
    logic [12:0] ctrl;
    logic [7:0]  mux;
    logic [2:0]  alu;
    logic [1:0]  cause;
    logic        n_chk;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0, int_req = 1'b0;

  logic       MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite;
  logic       PCWriteCond, Branch, EPCWrite, CauseWrite, int_ack;
  logic [2:0] ALU_operation;
  logic [4:0] state_out;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, Cause;

  logic       n_MemRead, n_MemWrite, n_CPU_MIO, n_IorD, n_IRWrite, n_RegWrite, n_ALUSrcA;
  logic       n_PCWrite, n_PCWriteCond, n_Branch, n_EPCWrite, n_CauseWrite, n_int_ack;
  logic [2:0] n_ALU_operation;
  logic [4:0] n_state_out;
  logic [1:0] n_RegDst, n_MemtoReg, n_ALUSrcB, n_PCSource, n_Cause;

  logic [12:0] act_ctrl;
  logic [7:0]  act_mux;
  assign act_ctrl = {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                     Branch, EPCWrite, CauseWrite, int_ack, CPU_MIO};
  assign act_mux  = {RegDst, MemtoReg, ALUSrcB, PCSource};

  always #5 clk = ~clk;

  mctrl_exc #(.ALU_OP_W(3), .STATE_W(5), .TIMEOUT(4), .INT_EN(1)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_operation(ALU_operation), .state_out(state_out), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .Cause(Cause), .int_ack(int_ack)
  );

  mctrl_exc #(.ALU_OP_W(3), .STATE_W(5), .TIMEOUT(4), .INT_EN(0)) dut_n (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .ALU_operation(n_ALU_operation), .state_out(n_state_out), .CPU_MIO(n_CPU_MIO),
    .IorD(n_IorD), .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .Branch(n_Branch), .RegDst(n_RegDst),
    .MemtoReg(n_MemtoReg), .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource),
    .EPCWrite(n_EPCWrite), .CauseWrite(n_CauseWrite), .Cause(n_Cause), .int_ack(n_int_ack)
  );

  int   n_checks = 0, n_fail = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] inst, input logic rdy, input logic ovf, input logic irq,
                     input logic [4:0] st, input logic [12:0] ctrl, input logic [7:0] mux,
                     input logic [2:0] alu, input logic [1:0] cause);
    vec_t v;
    v.inst = inst; v.rdy = rdy; v.ovf = ovf; v.irq = irq; v.st = st; v.ctrl = ctrl;
    v.mux = mux; v.alu = alu; v.cause = cause; v.n_chk = 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // add $3,$1,$2
    add(IAdd, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IAdd, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IAdd, 1, 0, 0, StExR, CSrcA,  M0,   AAdd, 2'b00);
    add(IAdd, 1, 0, 0, StWbR, CRegW,  MWbR, AAnd, 2'b00);
    // lw with three wait cycles; ready lands on the last allowed cycle (TIMEOUT=4)
    add(ILw,  1, 0, 0, StIf,   CIfRdy, MIf,  AAdd, 2'b00);
    add(ILw,  1, 0, 0, StId,   CNone,  MId,  AAdd, 2'b00);
    add(ILw,  0, 0, 0, StMa,   CSrcA,  MImm, AAdd, 2'b00);
    for (int k = 0; k < 3; k++) add(ILw, 0, 0, 0, StMrd, CMemRd, M0, AAnd, 2'b00);
    add(ILw,  1, 0, 0, StMrd,  CMemRd, M0,   AAnd, 2'b00);
    add(ILw,  1, 0, 0, StWbLw, CRegW,  M0,   AAnd, 2'b00);
    // ori
    add(IOri, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IOri, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IOri, 1, 0, 0, StExI, CSrcA,  MImm, AOr,  2'b00);
    add(IOri, 1, 0, 0, StWbI, CRegW,  MWbI, AAnd, 2'b00);
    // beq, jal, jr, lui
    add(IBeq, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IBeq, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IBeq, 1, 0, 0, StBeq, CBeq,   MBeq, ASub, 2'b00);
    add(IJal, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IJal, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IJal, 1, 0, 0, StJal, CJal,   MJal, AAnd, 2'b00);
    add(IJr,  1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IJr,  1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IJr,  1, 0, 0, StJr,  CJr,    M0,   AOr,  2'b00);
    add(ILui, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(ILui, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(ILui, 1, 0, 0, StLui, CRegW,  MLui, AAnd, 2'b00);
    // add overflow: exception, no RegWrite (interrupt raised mid-instruction is not taken)
    add(IAdd, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);
    add(IAdd, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b00);
    add(IAdd, 1, 1, 1, StExR, CSrcA,  M0,   AAdd, 2'b00);
    add(IAdd, 1, 0, 0, StExc, CExc,   MExc, AAnd, 2'b01);
    // illegal opcode
    add(IIll, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b01);
    add(IIll, 1, 0, 0, StId,  CNone,  MId,  AAdd, 2'b01);
    add(IIll, 1, 0, 0, StExc, CExc,   MExc, AAnd, 2'b10);
    // fetch never ready: four waiting cycles then bus timeout
    for (int k = 0; k < 4; k++) add(IAdd, 0, 0, 0, StIf, CIfWait, MIf, AAdd, 2'b10);
    add(IAdd, 1, 0, 0, StExc, CExc,   MExc, AAnd, 2'b11);
    // sw with interrupt pending: store completes, then interrupt taken
    add(ISw,  1, 0, 1, StIf,  CIfRdy, MIf,  AAdd, 2'b11);
    add(ISw,  1, 0, 1, StId,  CNone,  MId,  AAdd, 2'b11);
    add(ISw,  0, 0, 1, StMa,  CSrcA,  MImm, AAdd, 2'b11);
    add(ISw,  0, 0, 1, StMwr, CMemWr, M0,   AAnd, 2'b11);
    add(ISw,  1, 0, 1, StMwr, CMemWr, M0,   AAnd, 2'b11);
    add(ISw,  1, 0, 0, StExc, CExcInt, MExc, AAnd, 2'b00);
    tbl[tbl.size() - 1].n_chk = 1'b1;
    add(IAdd, 1, 0, 0, StIf,  CIfRdy, MIf,  AAdd, 2'b00);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state_out), 32'(StIf));
    check("reset strobes", 32'(act_ctrl), 32'h0);
    check("reset cause", 32'(Cause), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      Inst_in = tbl[i].inst; MIO_ready = tbl[i].rdy;
      overflow = tbl[i].ovf; int_req = tbl[i].irq;
      #1;
      check($sformatf("vec%0d state", i), 32'(state_out), 32'(tbl[i].st));
      check($sformatf("vec%0d ctrl", i), 32'(act_ctrl), 32'(tbl[i].ctrl));
      check($sformatf("vec%0d mux", i), 32'(act_mux), 32'(tbl[i].mux));
      check($sformatf("vec%0d alu", i), 32'(ALU_operation), 32'(tbl[i].alu));
      check($sformatf("vec%0d cause", i), 32'(Cause), 32'(tbl[i].cause));
      if (tbl[i].n_chk) begin
        check($sformatf("vec%0d int_en0 state", i), 32'(n_state_out), 32'(StIf));
        check($sformatf("vec%0d int_en0 ack", i), 32'(n_int_ack), 32'h0);
      end
      @(negedge clk);
    end

    // Reset asserted in the middle of a store
    reset = 1'b0; int_req = 1'b0; overflow = 1'b0;
    @(negedge clk);
    reset = 1'b1; Inst_in = ISw; MIO_ready = 1'b1;
    repeat (2) @(negedge clk);
    MIO_ready = 1'b0;
    @(negedge clk);
    #1;
    check("memwr entered", 32'(state_out), 32'(StMwr));
    check("memwr strobe", 32'(MemWrite), 32'h1);
    reset = 1'b0;
    #1;
    check("rst memwr drop", 32'(MemWrite), 32'h0);
    check("rst all strobes", 32'(act_ctrl), 32'h0);
    check("rst state", 32'(state_out), 32'(StIf));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post-rst state", 32'(state_out), 32'(StIf));
    check("post-rst fetch", 32'(act_ctrl), 32'(CIfWait));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
